// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the loader state encoding and the big-endian byte-lane placement.
package loader_pkg;

  typedef enum logic [2:0] {
    HALT,
    RECV,
    WRITE,
    RELEASE,
    RUN
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_BITS      = BYTES_PER_WORD * BYTE_W;
  localparam int IDX_W          = 2;

  // Big-endian lanes: the first byte of a word lands in the top byte.
  localparam int LANE0_LSB = 24;
  localparam int LANE1_LSB = 16;
  localparam int LANE2_LSB = 8;
  localparam int LANE3_LSB = 0;

  function automatic logic [WORD_BITS-1:0] place_byte(
    input logic [WORD_BITS-1:0] word,
    input logic [IDX_W-1:0]     idx,
    input logic [BYTE_W-1:0]    b
  );
    logic [WORD_BITS-1:0] w;
    w = word;
    case (idx)
      2'd0: w[LANE0_LSB +: BYTE_W] = b;
      2'd1: w[LANE1_LSB +: BYTE_W] = b;
      2'd2: w[LANE2_LSB +: BYTE_W] = b;
      default: w[LANE3_LSB +: BYTE_W] = b;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a stream of bytes into 32-bit big-endian words.
// The index wraps back to lane 0 after the fourth byte, ready for the next word.
module byte_packer
  import loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic [BYTE_W-1:0]    byte_in,
  output logic [WORD_BITS-1:0] word,
  output logic                 full
);

  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WORD_BITS-1:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear) begin
      idx_d  = '0;
      word_d = '0;
    end else if (load) begin
      idx_d  = idx_q + IDX_W'(1);
      word_d = place_byte(word_q, idx_q, byte_in);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  // Asserted while the next accepted byte completes the word.
  assign full = (idx_q == IDX_W'(BYTES_PER_WORD - 1));
  assign word = word_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a program byte stream into instruction memory, holding the CPU
// in reset until every word is written, then releasing it to run.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_data,
  output logic              imem_wren,
  output logic              cpu_rst,
  output logic              cpu_enable,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count
);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                byte_ready_q, byte_ready_d;
  logic                imem_wren_q, imem_wren_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                cpu_enable_q, cpu_enable_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                accept;
  logic                clear;
  logic                full;
  logic [WORD_BITS-1:0] packed_word;

  assign accept = byte_valid && (state_q == RECV);
  assign clear  = start && ((state_q == HALT) || (state_q == RUN));

  byte_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .load    (accept),
    .byte_in (byte_data),
    .word    (packed_word),
    .full    (full)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    case (state_q)
      HALT, RUN: begin
        if (start) begin
          len_d   = length;
          count_d = '0;
          state_d = (length == '0) ? RELEASE : RECV;
        end
      end
      RECV: begin
        if (accept && full) state_d = WRITE;
      end
      WRITE: begin
        count_d = count_q + (ADDR_W+1)'(1);
        state_d = (count_d == len_q) ? RELEASE : RECV;
      end
      RELEASE: state_d = RUN;
      default: state_d = HALT;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    byte_ready_d = (state_d == RECV);
    imem_wren_d  = (state_d == WRITE);
    cpu_rst_d    = (state_d != RUN);
    cpu_enable_d = (state_d == RUN);
    busy_d       = (state_d == RECV) || (state_d == WRITE) || (state_d == RELEASE);
    done_d       = (state_q == RELEASE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HALT;
      len_q        <= '0;
      count_q      <= '0;
      byte_ready_q <= 1'b0;
      imem_wren_q  <= 1'b0;
      cpu_rst_q    <= 1'b1;
      cpu_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      count_q      <= count_d;
      byte_ready_q <= byte_ready_d;
      imem_wren_q  <= imem_wren_d;
      cpu_rst_q    <= cpu_rst_d;
      cpu_enable_q <= cpu_enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_wren  = imem_wren_q;
  assign imem_addr  = count_q[ADDR_W-1:0];
  assign imem_data  = WORD_W'(packed_word);
  assign cpu_rst    = cpu_rst_q;
  assign cpu_enable = cpu_enable_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed loads with randomized bytes
// and handshake gaps, compared against a word/cycle model built from the byte stream.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int WORD_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   length;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_data;
  logic              imem_wren;
  logic              cpu_rst;
  logic              cpu_enable;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   word_count;

  imem_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .length     (length),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_wren  (imem_wren),
    .cpu_rst    (cpu_rst),
    .cpu_enable (cpu_enable),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          done_cyc_q[$];
  logic [2:0]  done_st_q[$];
  int          overlap = 0;

  logic [7:0]  tx[$];
  int          acc[$];

  int checks = 0;
  int fails  = 0;

  // Observe the memory-write and completion side of the DUT mid-cycle.
  always @(negedge clk) begin
    if (imem_wren) begin
      wr_addr_q.push_back(int'(imem_addr));
      wr_data_q.push_back(imem_data);
      wr_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cyc_q.push_back(cyc);
      done_st_q.push_back({cpu_enable, cpu_rst, busy});
    end
    if (imem_wren && byte_ready) overlap++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cyc_q.delete();
    done_st_q.delete();
    acc.delete();
    overlap = 0;
  endtask

  task automatic make_tx(input int nbytes, input int kind);
    tx.delete();
    for (int i = 0; i < nbytes; i++) begin
      if (kind == 0) tx.push_back(8'($urandom));
      else           tx.push_back(8'(i));
    end
  endtask

  task automatic start_load(input int n, output int s);
    clear_obs();
    @(negedge clk);
    length = (ADDR_W+1)'(n);
    start  = 1'b1;
    s      = cyc;
    @(negedge clk);
    start = 1'b0;
    check("start_ready", byte_ready, n != 0);
    check("start_cpu_rst", cpu_rst, 1);
    check("start_enable", cpu_enable, 0);
    check("start_busy", busy, 1);
    check("start_count", word_count, 0);
  endtask

  // mode 0: back-to-back, 1: valid toggles, 2: random gaps
  task automatic feed(input int mode, input bit pulses);
    int idx    = 0;
    int budget = 20000;
    bit phase  = 1'b1;
    while (idx < tx.size() && budget > 0) begin
      case (mode)
        0:       byte_valid = 1'b1;
        1:       byte_valid = phase;
        default: byte_valid = ($urandom_range(99) >= 40);
      endcase
      phase     = ~phase;
      byte_data = tx[idx];
      if (pulses && $urandom_range(6) == 0) begin
        start  = 1'b1;
        length = (ADDR_W+1)'($urandom_range(256));
      end else begin
        start = 1'b0;
      end
      if (byte_valid && byte_ready) begin
        acc.push_back(cyc);
        idx++;
      end
      @(negedge clk);
      budget--;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    check("feed_timeout", idx, tx.size());
  endtask

  task automatic finish_and_check(input int n, input int s, input string tag);
    int exp_done;
    repeat (6) @(negedge clk);
    check({tag, "_nwr"}, wr_addr_q.size(), n);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      logic [31:0] w;
      w = {tx[4*i], tx[4*i+1], tx[4*i+2], tx[4*i+3]};
      check({tag, "_addr"}, wr_addr_q[i], i);
      check({tag, "_data"}, wr_data_q[i], w);
      if (acc.size() == 4*n) check({tag, "_wcyc"}, wr_cyc_q[i], acc[4*i+3] + 1);
    end
    check({tag, "_ndone"}, done_cyc_q.size(), 1);
    if (done_cyc_q.size() > 0) begin
      exp_done = (n == 0) ? s + 2 : ((acc.size() == 4*n) ? acc[4*n-1] + 3 : -1);
      check({tag, "_done_cyc"}, done_cyc_q[0], exp_done);
      check({tag, "_done_state"}, done_st_q[0], 3'b100);
    end
    check({tag, "_count"}, word_count, n);
    check({tag, "_run_enable"}, cpu_enable, 1);
    check({tag, "_run_cpu_rst"}, cpu_rst, 0);
    check({tag, "_done_low"}, done, 0);
    check({tag, "_ready_in_write"}, overlap, 0);
    byte_valid = 1'b1;
    repeat (4) begin
      check({tag, "_late_ready"}, byte_ready, 0);
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  initial begin
    int s;
    int n;
    rst        = 1'b0;
    start      = 1'b0;
    length     = '0;
    byte_valid = 1'b0;
    byte_data  = '0;

    repeat (3) @(negedge clk);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_enable", cpu_enable, 0);
    check("rst_ready", byte_ready, 0);
    check("rst_wren", imem_wren, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_data", imem_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", word_count, 0);
    rst = 1'b1;

    repeat (20) begin
      @(negedge clk);
      check("idle_cpu_rst", cpu_rst, 1);
      check("idle_enable", cpu_enable, 0);
      check("idle_wren", imem_wren, 0);
    end

    tx.delete();
    tx = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h02, 8'h00, 8'h00};
    start_load(2, s);
    feed(0, 1'b0);
    finish_and_check(2, s, "b2b");

    start_load(2, s);
    feed(1, 1'b0);
    finish_and_check(2, s, "toggle");

    start_load(0, s);
    finish_and_check(0, s, "len0");

    make_tx(6, 0);
    start_load(2, s);
    feed(0, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_wren", imem_wren, 0);
    check("midrst_cpu_rst", cpu_rst, 1);
    check("midrst_enable", cpu_enable, 0);
    check("midrst_ready", byte_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", word_count, 0);
    check("midrst_nwr", wr_addr_q.size(), 1);
    if (wr_addr_q.size() > 0) begin
      check("midrst_addr", wr_addr_q[0], 0);
      check("midrst_data", wr_data_q[0], {tx[0], tx[1], tx[2], tx[3]});
    end
    @(negedge clk);
    rst = 1'b1;

    make_tx(8, 0);
    start_load(2, s);
    feed(2, 1'b0);
    finish_and_check(2, s, "reload");

    n = $urandom_range(40, 3);
    make_tx(4*n, 0);
    start_load(n, s);
    feed(2, 1'b1);
    finish_and_check(n, s, "rand");

    make_tx(1024, 1);
    start_load(256, s);
    feed(2, 1'b1);
    finish_and_check(256, s, "full");
    if (wr_addr_q.size() == 256) check("full_last_addr", wr_addr_q[255], 8'hFF);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
